reference_buffer: RTL and testbench

REFERENCE_BUFFER -- requirements
Module: reference_buffer

---
 rtl/reference_buffer_pkg.sv | 24 ++
 rtl/reference_buffer_row.sv | 58 +++++
 rtl/reference_buffer.sv | 91 +++++++++
 tb/tb_reference_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reference_buffer_pkg.sv
// ============================================================================
// Module : VSTypes (package)
// Brief  : Shared types and sizing for the reference buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package VSTypes;

  localparam int RB_NUM_ROWS = 4;
  localparam int RB_DEPTH    = 16;
  localparam int RB_CNT_W    = 5;
  localparam int RB_DATA_W   = 32;
  localparam int RB_IDX_W    = 4;
  localparam int RB_ROW_W    = 2;

  typedef struct packed {
    logic                 valid;
    logic [RB_DATA_W-1:0] data32b;
  } RBEntryType;

endpackage

`default_nettype wire

// File: rtl/reference_buffer_row.sv
// ============================================================================
// Module : reference_buffer_row
// Brief  : One row of 16 reference entries with occupancy count and invalidate.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reference_buffer_row
  import VSTypes::*;
(
  input  logic                 ClockIn,
  input  logic                 AsyncResetIn,
  input  logic                 WriteEn,
  input  logic                 WriteValid,
  input  logic [RB_IDX_W-1:0]  WriteIdx,
  input  logic [RB_DATA_W-1:0] WriteData,
  input  logic [RB_IDX_W-1:0]  RdIdx,
  output RBEntryType           RdEntry,
  output logic [RB_CNT_W-1:0]  Count
);

  localparam logic [RB_CNT_W-1:0] c_cntMax = RB_CNT_W'(RB_DEPTH);

  logic [RB_DEPTH-1:0]  r_valid;
  logic [RB_DATA_W-1:0] r_data [RB_DEPTH];
  logic [RB_CNT_W-1:0]  r_count;

  // Count only grows when a previously empty slot becomes valid.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (WriteEn) begin
      if (WriteValid) begin
        r_valid[WriteIdx] <= 1'b1;
        if (!r_valid[WriteIdx] && (r_count != c_cntMax)) begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_valid <= '0;
        r_count <= '0;
      end
    end
  end

  always_ff @(posedge ClockIn) begin
    if (WriteEn && WriteValid) begin
      r_data[WriteIdx] <= WriteData;
    end
  end

  assign RdEntry.valid   = r_valid[RdIdx];
  assign RdEntry.data32b = r_data[RdIdx];
  assign Count           = r_count;

endmodule

`default_nettype wire

// File: rtl/reference_buffer.sv
// ============================================================================
// Module : reference_buffer
// Brief  : 4-row reference buffer, one write/invalidate and one read per cycle.
//          Define RB_BYPASS_EN to forward same-cycle writes to the read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reference_buffer
  import VSTypes::*;
(
  input  logic                   ClockIn,
  input  logic                   AsyncResetIn,
  input  logic                   RB_WriteEn,
  input  logic                   RB_WriteValid,
  input  logic [RB_IDX_W-1:0]    RB_WriteIdx,
  input  logic [RB_ROW_W-1:0]    RB_PtrRegId,
  input  logic [RB_DATA_W-1:0]   RB_WriteData,
  input  logic                   RdReqIn,
  input  logic [RB_ROW_W-1:0]    RdPtrRegIdIn,
  input  logic [RB_IDX_W-1:0]    RdIdxIn,
  output logic                   RdValidOut,
  output logic                   RdHitOut,
  output logic [RB_DATA_W-1:0]   RdDataOut,
  output logic [RB_NUM_ROWS-1:0] RowFullOut,
  output logic [RB_NUM_ROWS-1:0] RowEmptyOut
);

  RBEntryType           w_rowEntry [RB_NUM_ROWS];
  logic [RB_CNT_W-1:0]  w_rowCount [RB_NUM_ROWS];
  RBEntryType           w_rdEntry;
  logic                 w_rdHit;
  logic [RB_DATA_W-1:0] w_rdData;

  for (genvar g = 0; g < RB_NUM_ROWS; g++) begin : g_rows
    reference_buffer_row u_row (
      .ClockIn      (ClockIn),
      .AsyncResetIn (AsyncResetIn),
      .WriteEn      (RB_WriteEn && (RB_PtrRegId == RB_ROW_W'(g))),
      .WriteValid   (RB_WriteValid),
      .WriteIdx     (RB_WriteIdx),
      .WriteData    (RB_WriteData),
      .RdIdx        (RdIdxIn),
      .RdEntry      (w_rowEntry[g]),
      .Count        (w_rowCount[g])
    );
    assign RowFullOut[g]  = (w_rowCount[g] == RB_CNT_W'(RB_DEPTH));
    assign RowEmptyOut[g] = (w_rowCount[g] == '0);
  end

  assign w_rdEntry = w_rowEntry[RdPtrRegIdIn];

`ifdef RB_BYPASS_EN
  logic w_collide;

  // An invalidate clears the whole row, so it collides with any index.
  assign w_collide = RB_WriteEn && (RB_PtrRegId == RdPtrRegIdIn) &&
                     (!RB_WriteValid || (RB_WriteIdx == RdIdxIn));

  always_comb begin
    w_rdHit  = w_rdEntry.valid;
    w_rdData = w_rdEntry.data32b;
    if (w_collide) begin
      w_rdHit  = RB_WriteValid;
      w_rdData = RB_WriteData;
    end
  end
`else
  assign w_rdHit  = w_rdEntry.valid;
  assign w_rdData = w_rdEntry.data32b;
`endif

  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      RdValidOut <= 1'b0;
      RdHitOut   <= 1'b0;
      RdDataOut  <= '0;
    end else if (RdReqIn) begin
      RdValidOut <= 1'b1;
      RdHitOut   <= w_rdHit;
      RdDataOut  <= w_rdHit ? w_rdData : '0;
    end else begin
      RdValidOut <= 1'b0;
      RdHitOut   <= 1'b0;
      RdDataOut  <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reference_buffer.sv
// ============================================================================
// Module : tb_reference_buffer
// Brief  : Directed self-checking bench for reference_buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reference_buffer;

`ifdef RB_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic        ClockIn = 1'b0;
  logic        AsyncResetIn;
  logic        RB_WriteEn, RB_WriteValid;
  logic [3:0]  RB_WriteIdx;
  logic [1:0]  RB_PtrRegId;
  logic [31:0] RB_WriteData;
  logic        RdReqIn;
  logic [1:0]  RdPtrRegIdIn;
  logic [3:0]  RdIdxIn;
  logic        RdValidOut, RdHitOut;
  logic [31:0] RdDataOut;
  logic [3:0]  RowFullOut, RowEmptyOut;

  int testCount = 0;
  int failCount = 0;

  reference_buffer dut (
    .ClockIn      (ClockIn),
    .AsyncResetIn (AsyncResetIn),
    .RB_WriteEn   (RB_WriteEn),
    .RB_WriteValid(RB_WriteValid),
    .RB_WriteIdx  (RB_WriteIdx),
    .RB_PtrRegId  (RB_PtrRegId),
    .RB_WriteData (RB_WriteData),
    .RdReqIn      (RdReqIn),
    .RdPtrRegIdIn (RdPtrRegIdIn),
    .RdIdxIn      (RdIdxIn),
    .RdValidOut   (RdValidOut),
    .RdHitOut     (RdHitOut),
    .RdDataOut    (RdDataOut),
    .RowFullOut   (RowFullOut),
    .RowEmptyOut  (RowEmptyOut)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic checkResult(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic setWrite(input logic en, input logic vld, input logic [1:0] row,
                          input logic [3:0] idx, input logic [31:0] data);
    RB_WriteEn    = en;
    RB_WriteValid = vld;
    RB_PtrRegId   = row;
    RB_WriteIdx   = idx;
    RB_WriteData  = data;
  endtask

  task automatic setRead(input logic req, input logic [1:0] row, input logic [3:0] idx);
    RdReqIn      = req;
    RdPtrRegIdIn = row;
    RdIdxIn      = idx;
  endtask

  task automatic writeEntry(input logic [1:0] row, input logic [3:0] idx,
                            input logic [31:0] data);
    setWrite(1'b1, 1'b1, row, idx, data);
    tick();
    setWrite(1'b0, 1'b0, 2'd0, 4'd0, 32'h0);
  endtask

  task automatic invalidateRow(input logic [1:0] row);
    setWrite(1'b1, 1'b0, row, 4'd0, 32'h0);
    tick();
    setWrite(1'b0, 1'b0, 2'd0, 4'd0, 32'h0);
  endtask

  task automatic readEntry(input logic [1:0] row, input logic [3:0] idx);
    setRead(1'b1, row, idx);
    tick();
    setRead(1'b0, 2'd0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    AsyncResetIn = 1'b0;
    setWrite(1'b0, 1'b0, 2'd0, 4'd0, 32'h0);
    setRead(1'b0, 2'd0, 4'd0);
    #1;
    checkResult("rst_valid", {31'h0, RdValidOut}, 32'h0);
    checkResult("rst_empty", {28'h0, RowEmptyOut}, 32'hF);
    checkResult("rst_full",  {28'h0, RowFullOut}, 32'h0);
    repeat (2) @(posedge ClockIn);
    #1 AsyncResetIn = 1'b1;

    // Miss on an empty buffer, then idle cycle clears the result
    readEntry(2'd2, 4'd5);
    checkResult("miss_valid", {31'h0, RdValidOut}, 32'h1);
    checkResult("miss_hit",   {31'h0, RdHitOut}, 32'h0);
    checkResult("miss_data",  RdDataOut, 32'h0);
    checkResult("miss_empty", {28'h0, RowEmptyOut}, 32'hF);
    tick();
    checkResult("idle_valid", {31'h0, RdValidOut}, 32'h0);

    writeEntry(2'd1, 4'd3, 32'hDEADBEEF);
    readEntry(2'd1, 4'd3);
    checkResult("wr_hit",   {31'h0, RdHitOut}, 32'h1);
    checkResult("wr_data",  RdDataOut, 32'hDEADBEEF);
    checkResult("wr_cnt1",  {27'h0, dut.w_rowCount[1]}, 32'd1);
    checkResult("wr_empty", {28'h0, RowEmptyOut}, 32'hD);

    // Fill row 0, overwrite, then invalidate
    for (int i = 0; i < 16; i++) writeEntry(2'd0, 4'(i), 32'h100 + i);
    checkResult("fill_cnt",  {27'h0, dut.w_rowCount[0]}, 32'd16);
    checkResult("fill_full", {28'h0, RowFullOut}, 32'h1);
    writeEntry(2'd0, 4'd7, 32'h0000CAFE);
    checkResult("ovw_cnt",  {27'h0, dut.w_rowCount[0]}, 32'd16);
    checkResult("ovw_full", {28'h0, RowFullOut}, 32'h1);
    readEntry(2'd0, 4'd7);
    checkResult("ovw_data", RdDataOut, 32'h0000CAFE);
    readEntry(2'd0, 4'd12);
    checkResult("fill_data12", RdDataOut, 32'h10C);
    invalidateRow(2'd0);
    checkResult("inv_cnt",   {27'h0, dut.w_rowCount[0]}, 32'd0);
    checkResult("inv_empty", {28'h0, RowEmptyOut}, 32'hD);
    checkResult("inv_full",  {28'h0, RowFullOut}, 32'h0);
    readEntry(2'd0, 4'd7);
    checkResult("inv_hit",  {31'h0, RdHitOut}, 32'h0);
    checkResult("inv_data", RdDataOut, 32'h0);

    // Same-cycle write and read collision
    setWrite(1'b1, 1'b1, 2'd3, 4'd9, 32'h12345678);
    setRead(1'b1, 2'd3, 4'd9);
    tick();
    setWrite(1'b0, 1'b0, 2'd0, 4'd0, 32'h0);
    setRead(1'b0, 2'd0, 4'd0);
    checkResult("col_wr_hit",  {31'h0, RdHitOut}, {31'h0, c_byp});
    checkResult("col_wr_data", RdDataOut, c_byp ? 32'h12345678 : 32'h0);
    readEntry(2'd3, 4'd9);
    checkResult("post_col_hit",  {31'h0, RdHitOut}, 32'h1);
    checkResult("post_col_data", RdDataOut, 32'h12345678);

    // Same-cycle invalidate and read collision
    setWrite(1'b1, 1'b0, 2'd3, 4'd0, 32'h0);
    setRead(1'b1, 2'd3, 4'd9);
    tick();
    setWrite(1'b0, 1'b0, 2'd0, 4'd0, 32'h0);
    setRead(1'b0, 2'd0, 4'd0);
    checkResult("col_inv_hit",  {31'h0, RdHitOut}, {31'h0, ~c_byp});
    checkResult("col_inv_data", RdDataOut, c_byp ? 32'h0 : 32'h12345678);
    checkResult("col_inv_cnt",  {27'h0, dut.w_rowCount[3]}, 32'd0);

    // Alternate invalidates of row 2 with writes to row 1
    writeEntry(2'd2, 4'd0, 32'h22222222);
    for (int k = 0; k < 4; k++) begin
      setWrite(1'b1, 1'b0, 2'd2, 4'd3, 32'hFFFFFFFF);
      setRead(1'b1, 2'd1, 4'd3);
      tick();
      setRead(1'b0, 2'd0, 4'd0);
      checkResult("alt_rd_data", RdDataOut, 32'hDEADBEEF);
      writeEntry(2'd1, 4'(4 + k), 32'hA0 + k);
    end
    checkResult("alt_cnt1", {27'h0, dut.w_rowCount[1]}, 32'd5);
    checkResult("alt_cnt2", {27'h0, dut.w_rowCount[2]}, 32'd0);
    readEntry(2'd1, 4'd6);
    checkResult("alt_data6", RdDataOut, 32'hA2);
    readEntry(2'd1, 4'd3);
    checkResult("alt_data3", RdDataOut, 32'hDEADBEEF);

    // Asynchronous reset with a read in flight
    for (int i = 0; i < 16; i++) writeEntry(2'd0, 4'(i), 32'h200 + i);
    checkResult("pre_rst_full", {28'h0, RowFullOut}, 32'h1);
    setRead(1'b1, 2'd0, 4'd1);
    tick();
    checkResult("pre_rst_valid", {31'h0, RdValidOut}, 32'h1);
    #2 AsyncResetIn = 1'b0;
    #1;
    checkResult("arst_valid", {31'h0, RdValidOut}, 32'h0);
    checkResult("arst_hit",   {31'h0, RdHitOut}, 32'h0);
    checkResult("arst_data",  RdDataOut, 32'h0);
    checkResult("arst_empty", {28'h0, RowEmptyOut}, 32'hF);
    checkResult("arst_full",  {28'h0, RowFullOut}, 32'h0);
    tick();
    setRead(1'b0, 2'd0, 4'd0);
    AsyncResetIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkResult("post_rst_valid", {31'h0, RdValidOut}, 32'h0);
    end
    readEntry(2'd0, 4'd1);
    checkResult("post_rst_hit", {31'h0, RdHitOut}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

`default_nettype wire
